dilated_activation_cache: RTL and testbench
===========================================

// Module: dilated_activation_cache
// PURPOSE
//   Buffers successive packed conv activations and presents four taps spaced DILATION pushes apart,
//   forming the dilated causal input window (a0..a3) for the next conv1d layer.
//   Sits between one conv1d output and the following conv1d input. The network state machine
//   pushes once per sample after the upstream conv's out_v.
//   Single clock domain; replaces the separately clocked cache with a push strobe.
// PARAMETERS
//   W         16  bits per element (signed)
//   D         8   elements per packed activation vector
//   DILATION  4   tap spacing in pushes; DEPTH = 3*DILATION+1 stored vectors
// PORTS
//   clk     in   1      system clock, all logic on posedge
//   rst_n   in   1      asynchronous active-low reset
//   push    in   1      1-cycle strobe: capture inp as newest vector
//   clear   in   1      synchronous clear of all stored vectors and pointer
//   inp     in   D*W    packed activation from upstream conv1d
//   out_l0  out  D*W    oldest tap, 3*DILATION pushes ago
//   out_l1  out  D*W    tap 2*DILATION pushes ago
//   out_l2  out  D*W    tap DILATION pushes ago
//   out_l3  out  D*W    newest tap, the current push
//   out_v   out  1      1-cycle pulse: taps updated
//   primed  out  1      present only with ACT_CACHE_PRIMED_EN
// BEHAVIOUR
//   - Storage: DEPTH x D*W register array used as a circular buffer; wr_ptr counts 0..DEPTH-1.
//   - Reset (rst_n low, async): all entries 0, wr_ptr 0, out_l0..3 = 0, out_v 0, primed 0.
//   - Push: write inp at wr_ptr; wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
//   - Taps are registered. The cycle after a push they load from the updated array, and out_v pulses high for exactly 1 cycle.
//     Latency from push to valid taps is 1 clk.
//   - Tap definition after the k-th push (x[k] = inp at push k; x[j] = 0 for j<1):
//     out_l3 = x[k], out_l2 = x[k-DILATION], out_l1 = x[k-2*DILATION], out_l0 = x[k-3*DILATION].
//   - Index arithmetic: newest = wr_ptr_prev; tap n index = (newest - n*DILATION) mod DEPTH.
//     Use add-DEPTH-and-compare; no divider.
//   - Wrap-around is transparent: pushes beyond DEPTH overwrite the oldest entry.
//     Taps stay correct indefinitely.
//   - Back-to-back pushes (push high every cycle) are legal. Each push produces its own out_v pulse one cycle later.
//   - Between pushes, taps and the array hold their values, and out_v stays 0.
//   - Clear: all entries 0, wr_ptr 0, taps 0, out_v 0, primed 0 on the next edge.
//   - Clear and push in the same cycle: clear wins and inp is discarded.
//   - Reset mid-operation aborts any pending out_v. The cache restarts as after power-up.
//   - Pure data movement: no arithmetic on element values, signedness preserved bit-exact.
// CONFIGURATION
//   ACT_CACHE_PRIMED_EN defined:
//     - Adds a fill counter that saturates at DEPTH.
//     - primed goes high together with the out_v of the DEPTH-th push after reset/clear, then stays high.
//     - primed returns to 0 on reset or clear.
//   ACT_CACHE_PRIMED_EN undefined:
//     - No counter and no primed port.
//     - Early taps read zeros, matching zero-padded causal conv.
// TESTING  (W=16, D=2, DILATION=4, DEPTH=13; lane values written as {hi,lo})
//   1. Assert rst_n=0, release, idle 5 clk -> all taps 0, out_v 0, primed 0.
//   2. Push {n,n} for n=1..13 with 3 idle clk between pushes.
//      -> After push 13: l3={13,13}, l2={9,9}, l1={5,5}, l0={1,1}.
//      -> out_v is a single pulse 1 clk after each push; primed rises with push 13's out_v.
//   3. Push n=1..30 back-to-back (push held high 30 clk).
//      -> Final taps l3=30, l2=26, l1=22, l0=18; 30 out_v pulses in total.
//   4. Push n=1..5 -> l3=5, l2=1, l1=0, l0=0. Also check negative data: push 0x8000 -> l3=0x8000 bit-exact.
//   5. Push n=1..13, then assert clear and push inp=99 in the same cycle.
//      -> All taps 0, no out_v, primed 0; the next push of 7 gives l3=7, others 0.
//   6. Drop rst_n asynchronously mid-clock during a back-to-back burst.
//      -> Outputs 0 immediately; after release, push 7 -> l3=7, l2=l1=l0=0.

Source files
------------

// File: rtl/dilated_activation_cache_if.sv
// Bundle between the network sequencer / upstream conv1d (master) and the
// dilated activation cache (slave).
// Handshake: push and clear are single-cycle strobes sampled on posedge clk,
// with no backpressure. out_v is a single-cycle pulse marking the cycle
// in which the four taps carry the window for the most recent push.
// The primed signal exists only when ACT_CACHE_PRIMED_EN is defined.
interface dilated_activation_cache_if #(
  parameter int W = 16,
  parameter int D = 8
);
  logic           push;
  logic           clear;
  logic [D*W-1:0] inp;
  logic [D*W-1:0] out_l0;
  logic [D*W-1:0] out_l1;
  logic [D*W-1:0] out_l2;
  logic [D*W-1:0] out_l3;
  logic           out_v;
`ifdef ACT_CACHE_PRIMED_EN
  logic           primed;
`endif

  modport master (
    output push, clear, inp,
`ifdef ACT_CACHE_PRIMED_EN
    input  primed,
`endif
    input  out_l0, out_l1, out_l2, out_l3, out_v
  );

  modport slave (
    input  push, clear, inp,
`ifdef ACT_CACHE_PRIMED_EN
    output primed,
`endif
    output out_l0, out_l1, out_l2, out_l3, out_v
  );
endinterface

// File: rtl/dilated_activation_cache.sv
// Dilated activation cache: a circular buffer of DEPTH = 3*DILATION+1 packed
// activation vectors. It presents the four taps x[k], x[k-DIL], x[k-2*DIL]
// and x[k-3*DIL] one cycle after the k-th push.
// Optional feature macro: ACT_CACHE_PRIMED_EN adds a fill counter and the
// primed flag. Without this macro, early taps read zeros, which gives
// zero-padded causal behaviour.
module dilated_activation_cache #(
  parameter int W        = 16,
  parameter int D        = 8,
  parameter int DILATION = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dilated_activation_cache_if.slave   bus
);
  localparam int DEPTH = 3 * DILATION + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int DW    = D * W;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] newest;     // slot written by the push being presented
  logic          pend;       // a push happened last cycle; taps load now
  logic [DW-1:0] tap_q [4];
  logic          out_v_q;
  logic [PW-1:0] tap_idx [4];

  // Slot that lies n*DILATION pushes behind base. The subtraction is done
  // modulo DEPTH by adding DEPTH and conditionally subtracting it once.
  function automatic logic [PW-1:0] tap_index(input logic [PW-1:0] base, input int n);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(DEPTH - n * DILATION);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // Read addresses for the four taps, relative to the newest slot.
  always_comb begin
    for (int n = 0; n < 4; n++) tap_idx[n] = tap_index(newest, n);
  end

  // Storage, write pointer and tap registers. The oldest tap reads the slot
  // that the next push overwrites. The read sees the pre-write value, so
  // back-to-back pushes stay correct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      newest  <= '0;
      pend    <= 1'b0;
      out_v_q <= 1'b0;
      for (int n = 0; n < 4; n++) tap_q[n] <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      newest  <= '0;
      pend    <= 1'b0;
      out_v_q <= 1'b0;
      for (int n = 0; n < 4; n++) tap_q[n] <= '0;
    end else begin
      if (bus.push) begin
        mem[wr_ptr] <= bus.inp;
        newest      <= wr_ptr;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      pend    <= bus.push;
      out_v_q <= pend;
      if (pend) begin
        // tap_q[n] holds the value from n*DILATION pushes ago. Tap 0 is the newest.
        for (int n = 0; n < 4; n++) tap_q[n] <= mem[tap_idx[n]];
      end
    end
  end

  assign bus.out_l3 = tap_q[0];
  assign bus.out_l2 = tap_q[1];
  assign bus.out_l1 = tap_q[2];
  assign bus.out_l0 = tap_q[3];
  assign bus.out_v  = out_v_q;

`ifdef ACT_CACHE_PRIMED_EN
  logic [PW:0] fill_cnt;
  logic        primed_q;

  // Count pushes since reset or clear, saturating at DEPTH. primed rises
  // with the out_v of the DEPTH-th push and then holds high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
      primed_q <= 1'b0;
    end else if (bus.clear) begin
      fill_cnt <= '0;
      primed_q <= 1'b0;
    end else begin
      if (bus.push && fill_cnt != (PW+1)'(DEPTH)) fill_cnt <= fill_cnt + 1'b1;
      if (pend && fill_cnt == (PW+1)'(DEPTH)) primed_q <= 1'b1;
    end
  end

  assign bus.primed = primed_q;
`endif
endmodule

// File: tb/tb_dilated_activation_cache.sv
// Bench for dilated_activation_cache with W=16, D=2 and DILATION=4 (DEPTH=13).
// Lane values are {hi,lo}. Build with +define+ACT_CACHE_PRIMED_EN to also
// check the primed flag.
module tb_dilated_activation_cache;
  localparam int W = 16;
  localparam int D = 2;
  localparam int DW = D * W;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;
  int v_cnt;
  logic [DW-1:0] exp_q[$];

  dilated_activation_cache_if #(.W(W), .D(D)) bus ();

  dilated_activation_cache #(.W(W), .D(D), .DILATION(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every out_v pulse must carry the newest pushed vector on out_l3.
  always @(negedge clk) begin
    if (rst_n && bus.out_v) begin
      v_cnt++;
      if (exp_q.size() == 0) check("sb_unexpected_v", 1, 0);
      else check("sb_l3", bus.out_l3, exp_q.pop_front());
    end
  end

  function automatic logic [DW-1:0] vv(input int n);
    logic [15:0] h;
    h = 16'(n);
    return {h, h};
  endfunction

  // Driver tasks. Each task is entered and left at posedge+1.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [DW-1:0] v);
    bus.push = 1'b1;
    bus.inp  = v;
    exp_q.push_back(v);
    tick(1);
    bus.push = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
  endtask

  task automatic check_taps(input string tag, input logic [DW-1:0] e3, input logic [DW-1:0] e2,
                            input logic [DW-1:0] e1, input logic [DW-1:0] e0);
    check({tag, "_l3"}, bus.out_l3, e3);
    check({tag, "_l2"}, bus.out_l2, e2);
    check({tag, "_l1"}, bus.out_l1, e1);
    check({tag, "_l0"}, bus.out_l0, e0);
  endtask

  initial begin
    int v0;
    n_cmp = 0; n_bad = 0; v_cnt = 0;
    bus.push = 1'b0; bus.clear = 1'b0; bus.inp = '0;
    rst_n = 1'b0;

    // 1: reset state.
    tick(3);
    rst_n = 1'b1;
    tick(5);
    @(negedge clk);
    check_taps("rst", 0, 0, 0, 0);
    check("rst_v", bus.out_v, 0);
`ifdef ACT_CACHE_PRIMED_EN
    check("rst_primed", bus.primed, 0);
`endif
    tick(1);

    // 2: spaced pushes, each producing a single out_v pulse one cycle later.
    for (int n = 1; n <= 13; n++) begin
      do_push(vv(n));
      @(negedge clk); check("sp_v_early", bus.out_v, 0);
      @(negedge clk); check("sp_v_pulse", bus.out_v, 1);
`ifdef ACT_CACHE_PRIMED_EN
      check("sp_primed", bus.primed, (n == 13) ? 1 : 0);
`endif
      @(negedge clk); check("sp_v_drop", bus.out_v, 0);
      tick(1);
    end
    @(negedge clk);
    check_taps("sp", vv(13), vv(9), vv(5), vv(1));
    tick(1);

    // 3: 30 back-to-back pushes.
    v0 = v_cnt;
    for (int n = 1; n <= 30; n++) do_push(vv(n));
    tick(3);
    @(negedge clk);
    check_taps("b2b", vv(30), vv(26), vv(22), vv(18));
    check("b2b_vcnt", 64'(v_cnt - v0), 30);
    tick(1);

    // 4: partial fill after clear, then negative data.
    do_clear();
    for (int n = 1; n <= 5; n++) do_push(vv(n));
    tick(2);
    @(negedge clk);
    check_taps("part", vv(5), vv(1), 0, 0);
`ifdef ACT_CACHE_PRIMED_EN
    check("part_primed", bus.primed, 0);
`endif
    tick(1);
    do_push(32'h8000_8000);
    tick(1);
    @(negedge clk);
    check_taps("neg", 32'h8000_8000, vv(2), 0, 0);
    tick(1);

    // 5: clear and push in the same cycle. The clear wins.
    do_clear();
    for (int n = 1; n <= 13; n++) do_push(vv(n));
    tick(3);
    v0 = v_cnt;
    bus.clear = 1'b1; bus.push = 1'b1; bus.inp = vv(99);
    tick(1);
    bus.clear = 1'b0; bus.push = 1'b0;
    tick(3);
    @(negedge clk);
    check_taps("clr", 0, 0, 0, 0);
    check("clr_no_v", 64'(v_cnt - v0), 0);
`ifdef ACT_CACHE_PRIMED_EN
    check("clr_primed", bus.primed, 0);
`endif
    tick(1);
    do_push(vv(7));
    tick(1);
    @(negedge clk);
    check_taps("clr_p7", vv(7), 0, 0, 0);
    tick(1);

    // 6: asynchronous reset in the middle of a burst.
    for (int n = 1; n <= 6; n++) do_push(vv(n + 40));
    bus.push = 1'b1; bus.inp = vv(47);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_taps("arst", 0, 0, 0, 0);
    check("arst_v", bus.out_v, 0);
    bus.push = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    @(negedge clk);
    check("arst_v_after", bus.out_v, 0);
    tick(1);
    do_push(vv(7));
    tick(1);
    @(negedge clk);
    check_taps("arst_p7", vv(7), 0, 0, 0);

    tick(2);
    check("sb_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
